// File: rtl/sfx_scheduler_pkg.sv
// Shared definitions for the sound-effect scheduler: FSM encoding, effect ids, terminator test.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sfx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_PLAY  = 2'd3
    } state_t;

    localparam logic [1:0] SFX_ID0 = 2'd0;
    localparam logic [1:0] SFX_ID1 = 2'd1;
    localparam logic [1:0] SFX_ID2 = 2'd2;
    localparam logic [1:0] SFX_ID3 = 2'd3;

    // A frame with zero half-period and zero duration marks the end of an effect.
    function automatic logic is_terminator(input logic [15:0] period, input logic [9:0] dur);
        return (period == 16'd0) && (dur == 10'd0);
    endfunction

endpackage

// File: rtl/sfx_priority_enc.sv
// Picks the highest-numbered set bit of the pending mask as the next effect to grant.
// Latency: purely combinational.
// Backpressure: none; found is low when the mask is empty.
module sfx_priority_enc
    import sfx_scheduler_pkg::*;
(
    input  logic [3:0] i_pend,
    output logic       o_found,
    output logic [1:0] o_id
);

    // Fixed priority, bit 3 wins
    always_comb begin
        o_found = |i_pend;
        o_id    = SFX_ID0;
        if (i_pend[3]) begin
            o_id = SFX_ID3;
        end else if (i_pend[2]) begin
            o_id = SFX_ID2;
        end else if (i_pend[1]) begin
            o_id = SFX_ID1;
        end
    end

endmodule

// File: rtl/sfx_scheduler.sv
// Four-effect sound scheduler: arbitrates requests, walks frame tables in ROM, drives a square synth.
// Latency: grant on the cycle after REQ; frame data reaches the synth two cycles after the grant.
// Backpressure: none; requests accumulate in a pending mask, TICK pulses are consumed only in PLAY.
module sfx_scheduler
    import sfx_scheduler_pkg::*;
#(
    parameter int                ADDR_W = 8,
    parameter logic [ADDR_W-1:0] START0 = ADDR_W'(8'h00),
    parameter logic [ADDR_W-1:0] START1 = ADDR_W'(8'h10),
    parameter logic [ADDR_W-1:0] START2 = ADDR_W'(8'h20),
    parameter logic [ADDR_W-1:0] START3 = ADDR_W'(8'h30)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              TICK,
    input  logic [3:0]        REQ,
    output logic [ADDR_W-1:0] FRAME_ADDR,
    input  logic [15:0]       FRAME_PERIOD,
    input  logic [9:0]        FRAME_DUR,
    output logic [15:0]       SYNTH_PERIOD,
    output logic              SYNTH_ENABLE,
    output logic              BUSY,
    output logic [1:0]        ACTIVE_ID,
    output logic              DONE
);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_pend, w_pend_nxt, w_pend;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt, w_start;
    logic [15:0]       r_per, w_per_nxt;
    logic              r_en, w_en_nxt;
    logic              r_done, w_done_nxt;
    logic [1:0]        r_id, w_id_nxt, w_gid;
    logic [9:0]        r_dur, w_dur_nxt;
    logic [9:0]        r_pos, w_pos_nxt;
    logic              w_found, w_preempt, w_grant, w_end;

    // Same-cycle requests take part in arbitration, so a granted REQ pulse is consumed at once.
    assign w_pend = r_pend | REQ;

    sfx_priority_enc u_prio (
        .i_pend  (w_pend),
        .o_found (w_found),
        .o_id    (w_gid)
    );

    // Equal id means a retrigger of the running effect, handled exactly like a preemption.
    assign w_preempt = w_found && (w_gid >= r_id);

    // Frame-table start address of the effect the encoder selected
    always_comb begin
        case (w_gid)
            SFX_ID3: w_start = START3;
            SFX_ID2: w_start = START2;
            SFX_ID1: w_start = START1;
            default: w_start = START0;
        endcase
    end

    // Next-state and datapath updates; preemption overrides frame end and terminator handling
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = w_pend;
        w_addr_nxt  = r_addr;
        w_per_nxt   = r_per;
        w_en_nxt    = r_en;
        w_done_nxt  = 1'b0;
        w_id_nxt    = r_id;
        w_dur_nxt   = r_dur;
        w_pos_nxt   = r_pos;
        w_grant     = 1'b0;
        w_end       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_grant = w_found;
            end
            ST_FETCH: begin
                if (w_preempt) begin
                    w_grant = 1'b1;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_preempt) begin
                    w_grant = 1'b1;
                end else if (is_terminator(FRAME_PERIOD, FRAME_DUR)) begin
                    w_end = 1'b1;
                end else begin
                    // A rest frame keeps the previous half-period so the synth sees no glitch value.
                    if (FRAME_PERIOD != 16'd0) begin
                        w_per_nxt = FRAME_PERIOD;
                    end
                    w_en_nxt    = (FRAME_PERIOD != 16'd0);
                    w_dur_nxt   = FRAME_DUR;
                    w_pos_nxt   = 10'd0;
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_preempt) begin
                    w_grant = 1'b1;
                end else if (TICK) begin
                    if (r_pos == r_dur) begin
                        // The last table entry ends the effect instead of wrapping to address 0.
                        if (r_addr == {ADDR_W{1'b1}}) begin
                            w_end = 1'b1;
                        end else begin
                            w_addr_nxt  = r_addr + ADDR_W'(1);
                            w_state_nxt = ST_FETCH;
                        end
                    end else begin
                        w_pos_nxt = r_pos + 10'd1;
                    end
                end
            end
        endcase

        if (w_end) begin
            w_done_nxt  = 1'b1;
            w_en_nxt    = 1'b0;
            w_state_nxt = ST_IDLE;
            w_grant     = w_found;
        end

        if (w_grant) begin
            w_id_nxt           = w_gid;
            w_addr_nxt         = w_start;
            w_en_nxt           = 1'b0;
            w_state_nxt        = ST_FETCH;
            w_pend_nxt[w_gid]  = 1'b0;
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_pend  <= 4'd0;
            r_addr  <= '0;
            r_per   <= 16'd0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_id    <= 2'd0;
            r_dur   <= 10'd0;
            r_pos   <= 10'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_addr  <= w_addr_nxt;
            r_per   <= w_per_nxt;
            r_en    <= w_en_nxt;
            r_done  <= w_done_nxt;
            r_id    <= w_id_nxt;
            r_dur   <= w_dur_nxt;
            r_pos   <= w_pos_nxt;
        end
    end

    assign FRAME_ADDR   = r_addr;
    assign SYNTH_PERIOD = r_per;
    assign SYNTH_ENABLE = r_en;
    assign BUSY         = (r_state != ST_IDLE);
    assign ACTIVE_ID    = r_id;
    assign DONE         = r_done;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Self-checking bench: effect-level reference model compared every cycle, plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_sfx_scheduler;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        TICK = 1'b0;
    logic [3:0]  REQ = 4'd0;
    logic [7:0]  FRAME_ADDR;
    logic [15:0] FRAME_PERIOD = 16'd0;
    logic [9:0]  FRAME_DUR = 10'd0;
    logic [15:0] SYNTH_PERIOD;
    logic        SYNTH_ENABLE;
    logic        BUSY;
    logic [1:0]  ACTIVE_ID;
    logic        DONE;

    logic [15:0] rom_per [256];
    logic [9:0]  rom_dur [256];

    int n_cmp = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_tick_en = 0;

    // Reference model: effect-level view (who plays, where in its table, how many ticks remain)
    logic        m_busy = 1'b0;
    int          m_id = 0;
    logic [7:0]  m_addr = 8'd0;
    int          m_wait = 0;     // cycles until the addressed frame takes effect: 2, 1, then 0 = sounding
    int          m_left = 0;     // ticks still to elapse in the current frame
    logic [15:0] m_per = 16'd0;
    logic        m_en = 1'b0;
    logic        m_done = 1'b0;
    logic [3:0]  m_pend = 4'd0;

    sfx_scheduler dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .TICK         (TICK),
        .REQ          (REQ),
        .FRAME_ADDR   (FRAME_ADDR),
        .FRAME_PERIOD (FRAME_PERIOD),
        .FRAME_DUR    (FRAME_DUR),
        .SYNTH_PERIOD (SYNTH_PERIOD),
        .SYNTH_ENABLE (SYNTH_ENABLE),
        .BUSY         (BUSY),
        .ACTIVE_ID    (ACTIVE_ID),
        .DONE         (DONE)
    );

    always #5 CLK = ~CLK;

    // Synchronous frame ROM: data appears one cycle after the address
    always @(posedge CLK) begin
        FRAME_PERIOD <= rom_per[FRAME_ADDR];
        FRAME_DUR    <= rom_dur[FRAME_ADDR];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int top_bit(input logic [3:0] p);
        for (int b = 3; b >= 0; b--) begin
            if (p[b]) return b;
        end
        return -1;
    endfunction

    function automatic logic [7:0] start_of(input int e);
        return 8'(e * 16);
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_id = 0; m_addr = 8'd0; m_wait = 0; m_left = 0;
        m_per = 16'd0; m_en = 1'b0; m_done = 1'b0; m_pend = 4'd0;
    endtask

    task automatic model_step(input logic [3:0] req, input logic tick);
        logic [3:0] pend;
        int top;
        bit start_new;
        bit finish;
        pend = m_pend | req;
        top = top_bit(pend);
        m_done = 1'b0;
        start_new = 1'b0;
        finish = 1'b0;
        if (!m_busy) begin
            start_new = (top >= 0);
        end else if (top >= m_id) begin
            start_new = 1'b1;
        end else if (m_wait == 2) begin
            m_wait = 1;
        end else if (m_wait == 1) begin
            if (rom_per[m_addr] == 16'd0 && rom_dur[m_addr] == 10'd0) begin
                finish = 1'b1;
            end else begin
                if (rom_per[m_addr] != 16'd0) m_per = rom_per[m_addr];
                m_en = (rom_per[m_addr] != 16'd0);
                m_left = int'(rom_dur[m_addr]) + 1;
                m_wait = 0;
            end
        end else if (tick) begin
            m_left--;
            if (m_left == 0) begin
                if (m_addr == 8'hFF) begin
                    finish = 1'b1;
                end else begin
                    m_addr = m_addr + 8'd1;
                    m_wait = 2;
                end
            end
        end
        if (finish) begin
            m_done = 1'b1;
            m_en = 1'b0;
            m_busy = 1'b0;
            start_new = (top >= 0);
        end
        if (start_new) begin
            m_id = top;
            m_addr = start_of(top);
            m_wait = 2;
            m_en = 1'b0;
            m_busy = 1'b1;
            pend[top] = 1'b0;
        end
        m_pend = pend;
    endtask

    // Compare process: advance the model on each edge (or clear it on reset) and check all outputs
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) model_reset();
        else model_step(REQ, TICK);
        #1;
        check("cycle", {FRAME_ADDR, SYNTH_PERIOD, SYNTH_ENABLE, BUSY, ACTIVE_ID, DONE},
              {m_addr, m_per, m_en, m_busy, 2'(m_id), m_done});
    end

    task automatic step(input logic [3:0] r, input logic t);
        @(negedge CLK);
        REQ = r;
        TICK = t;
        if (t && SYNTH_ENABLE) n_tick_en++;
        @(posedge CLK);
        #2;
        REQ = 4'd0;
        TICK = 1'b0;
        if (DONE) n_done++;
    endtask

    task automatic run_until_done(input int budget);
        int k = 0;
        while (!DONE && k < budget) begin
            step(4'd0, (k % 4) == 1);
            k++;
        end
        check("done_seen", DONE, 1'b1);
    endtask

    task automatic run_until_idle(input int budget);
        int k = 0;
        while (BUSY && k < budget) begin
            step(4'd0, (k % 4) == 1);
            k++;
        end
        check("idle_reached", BUSY, 1'b0);
    endtask

    task automatic set_frame(input int a, input int per, input int dur);
        rom_per[a] = 16'(per);
        rom_dur[a] = 10'(dur);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) set_frame(a, 0, 0);
        repeat (3) @(negedge CLK);
        check("reset_state", {FRAME_ADDR, SYNTH_PERIOD, SYNTH_ENABLE, BUSY, ACTIVE_ID, DONE}, 64'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Single effect: 100 for 3 ticks, then terminator
        set_frame(8'h00, 100, 2);
        set_frame(8'h01, 0, 0);
        step(4'b0001, 1'b0);
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        check("basic_period", SYNTH_PERIOD, 16'd100);
        check("basic_enable", SYNTH_ENABLE, 1'b1);
        n_done = 0;
        n_tick_en = 0;
        run_until_done(100);
        check("basic_ticks_enabled", n_tick_en, 3);
        check("basic_busy_at_done", BUSY, 1'b0);
        step(4'd0, 1'b0);
        check("basic_done_once", n_done, 1);

        // Preemption of effect 0 by effect 2
        set_frame(8'h00, 100, 5);
        set_frame(8'h20, 50, 0);
        set_frame(8'h21, 60, 1);
        set_frame(8'h22, 0, 0);
        step(4'b0001, 1'b0);
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        step(4'd0, 1'b1);
        n_done = 0;
        step(4'b0100, 1'b0);
        check("preempt_enable", SYNTH_ENABLE, 1'b0);
        check("preempt_addr", FRAME_ADDR, 8'h20);
        check("preempt_id", ACTIVE_ID, 2'd2);
        check("preempt_no_done", DONE, 1'b0);
        run_until_idle(200);
        check("preempt_done_count", n_done, 1);

        // Retrigger of effect 2 from its second frame
        step(4'b0100, 1'b0);
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        step(4'd0, 1'b1);
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        check("retrig_second_frame", FRAME_ADDR, 8'h21);
        n_done = 0;
        step(4'b0100, 1'b0);
        check("retrig_addr", FRAME_ADDR, 8'h20);
        check("retrig_id", ACTIVE_ID, 2'd2);
        run_until_idle(200);
        check("retrig_done_once", n_done, 1);

        // Simultaneous requests 3 and 0: 3 first, then 0 without a new pulse
        set_frame(8'h30, 200, 0);
        set_frame(8'h31, 0, 0);
        n_done = 0;
        step(4'b1001, 1'b0);
        check("dual_first_id", ACTIVE_ID, 2'd3);
        run_until_done(100);
        check("dual_second_id", ACTIVE_ID, 2'd0);
        check("dual_second_addr", FRAME_ADDR, 8'h00);
        check("dual_busy", BUSY, 1'b1);
        run_until_idle(200);
        check("dual_done_count", n_done, 2);

        // Rest frame of 5 ticks followed by a tone
        set_frame(8'h10, 0, 4);
        set_frame(8'h11, 77, 0);
        set_frame(8'h12, 0, 0);
        step(4'b0010, 1'b0);
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(4'd0, 1'b1);
            step(4'd0, 1'b0);
        end
        check("rest_enable", SYNTH_ENABLE, 1'b0);
        check("rest_busy", BUSY, 1'b1);
        step(4'd0, 1'b1);
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        check("after_rest_enable", SYNTH_ENABLE, 1'b1);
        check("after_rest_period", SYNTH_PERIOD, 16'd77);
        run_until_idle(200);

        // Reset during play with effect 1 pending
        step(4'b1000, 1'b0);
        step(4'd0, 1'b0);
        step(4'd0, 1'b0);
        step(4'b0010, 1'b0);
        @(negedge CLK);
        RESET_N = 1'b0;
        REQ = 4'b0001;
        #1;
        check("midreset_outputs", {FRAME_ADDR, SYNTH_PERIOD, SYNTH_ENABLE, BUSY, ACTIVE_ID, DONE}, 64'd0);
        repeat (3) @(negedge CLK);
        REQ = 4'd0;
        RESET_N = 1'b1;
        for (int i = 0; i < 10; i++) step(4'd0, 1'b1);
        check("post_reset_idle", BUSY, 1'b0);
        check("post_reset_addr", FRAME_ADDR, 8'h00);

        // Effect 3 runs to the last table address and ends there
        for (int a = 8'h30; a < 8'hFF; a++) set_frame(a, int'($urandom_range(1, 500)), 0);
        set_frame(8'hFF, 33, 0);
        step(4'b1000, 1'b0);
        run_until_done(3000);
        check("top_addr_end", FRAME_ADDR, 8'hFF);
        check("top_addr_idle", BUSY, 1'b0);
        check("top_addr_period", SYNTH_PERIOD, 16'd33);

        // Randomized tables and traffic
        for (int e = 0; e < 4; e++) begin
            int nf;
            nf = int'($urandom_range(1, 3));
            for (int f = 0; f < nf; f++) begin
                set_frame(e * 16 + f,
                          ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4000)),
                          int'($urandom_range(0, 3)));
            end
            set_frame(e * 16 + nf, 0, 0);
        end
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(negedge CLK);
                RESET_N = 1'b0;
                repeat (2) @(negedge CLK);
                RESET_N = 1'b1;
            end
            step(($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                 1'($urandom_range(0, 1)));
        end

        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
